// File: rtl/cci_mpf_shim_event_ctrs_if.sv
// CSR/event bundle for the MPF shim event counters.
// The master side drives events and reads; the slave side answers them.
interface cci_mpf_shim_event_ctrs_if #(
    parameter int N_EVENTS = 4
);
    localparam int IDX_WIDTH = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1;

    logic [N_EVENTS-1:0]  events;
    logic                 csr_clr;
    logic                 csr_freeze;
    logic                 csr_rd_en;
    logic [IDX_WIDTH-1:0] csr_rd_idx;
    logic                 csr_rd_valid;
    logic [63:0]          csr_rd_data;

    modport master (
        output events, csr_clr, csr_freeze, csr_rd_en, csr_rd_idx,
        input  csr_rd_valid, csr_rd_data
    );

    modport slave (
        input  events, csr_clr, csr_freeze, csr_rd_en, csr_rd_idx,
        output csr_rd_valid, csr_rd_data
    );
endinterface

// File: rtl/cci_mpf_shim_event_ctrs.sv
// Per-channel event counters with sticky overflow and 1-cycle CSR readback.
// Define CCI_MPF_EVENT_CTR_SATURATE_EN to hold at all-ones instead of wrapping.
module cci_mpf_shim_event_ctrs #(
    parameter int N_EVENTS  = 4,
    parameter int CTR_WIDTH = 48
) (
    input  logic clk,
    input  logic reset,
    cci_mpf_shim_event_ctrs_if.slave bus
);
    localparam int IDX_WIDTH = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1;

    logic [N_EVENTS-1:0]       ev_q_reg;
    logic [N_EVENTS-1:0][63:0] ch_word;
    logic [63:0]               sel_word;
    logic                      rd_valid_reg;
    logic [63:0]               rd_data_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ev_q_reg <= '0;
        end else begin
            ev_q_reg <= bus.events;
        end
    end

    generate
        for (genvar gi = 0; gi < N_EVENTS; gi++) begin : g_ch
            logic [CTR_WIDTH-1:0] ctr_reg;
            logic                 ovf_reg;
            logic                 at_max;
            logic [63:0]          word;

            assign at_max = &ctr_reg;

            // Clear wins over freeze and increment; frozen ev_q bits are dropped.
            always_ff @(posedge clk) begin
                if (reset || bus.csr_clr) begin
                    ctr_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (ev_q_reg[gi] && !bus.csr_freeze) begin
                    ovf_reg <= ovf_reg | at_max;
`ifdef CCI_MPF_EVENT_CTR_SATURATE_EN
                    ctr_reg <= at_max ? ctr_reg : ctr_reg + CTR_WIDTH'(1);
`else
                    ctr_reg <= ctr_reg + CTR_WIDTH'(1);
`endif
                end
            end

            always_comb begin
                word                  = '0;
                word[63]              = ovf_reg;
                word[CTR_WIDTH-1:0]   = ctr_reg;
            end

            assign ch_word[gi] = word;
        end
    endgenerate

    // Out-of-range indices match no channel and therefore read as zero.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_EVENTS; i++) begin
            if (bus.csr_rd_idx == IDX_WIDTH'(i)) begin
                sel_word = ch_word[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= bus.csr_rd_en;
            rd_data_reg  <= bus.csr_rd_en ? sel_word : 64'd0;
        end
    end

    assign bus.csr_rd_valid = rd_valid_reg;
    assign bus.csr_rd_data  = rd_data_reg;
endmodule

// File: tb/tb_cci_mpf_shim_event_ctrs.sv
// Directed checks of the event counters: table-driven vectors plus hand sequences.
module tb_cci_mpf_shim_event_ctrs;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    cci_mpf_shim_event_ctrs_if #(.N_EVENTS(4)) bus_a ();
    cci_mpf_shim_event_ctrs_if #(.N_EVENTS(3)) bus_b ();

    cci_mpf_shim_event_ctrs #(.N_EVENTS(4), .CTR_WIDTH(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    cci_mpf_shim_event_ctrs #(.N_EVENTS(3), .CTR_WIDTH(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ev;
        logic        clr;
        logic        frz;
        logic        rd;
        logic [1:0]  idx;
        logic        exp_v;
        logic [63:0] exp_d;
    } vec_t;

    vec_t tbl [25];

`ifdef CCI_MPF_EVENT_CTR_SATURATE_EN
    localparam logic [63:0] OVF_1 = 64'h8000_0000_0000_00FF;
    localparam logic [63:0] OVF_2 = 64'h8000_0000_0000_00FF;
`else
    localparam logic [63:0] OVF_1 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] OVF_2 = 64'h8000_0000_0000_0001;
`endif

    function automatic vec_t mk(input logic [3:0] ev, input logic clr, input logic frz,
                                input logic rd, input logic [1:0] idx,
                                input logic exp_v, input logic [63:0] exp_d);
        vec_t v;
        v.ev = ev; v.clr = clr; v.frz = frz; v.rd = rd; v.idx = idx;
        v.exp_v = exp_v; v.exp_d = exp_d;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic act_v, input logic [63:0] act_d,
                         input logic exp_v, input logic [63:0] exp_d);
        total++;
        if (act_v !== exp_v || act_d !== exp_d) begin
            bad++;
            $display("FAIL %s: got valid=%0b data=%h, want valid=%0b data=%h",
                     name, act_v, act_d, exp_v, exp_d);
        end else begin
            $display("ok   %s: valid=%0b data=%h", name, act_v, act_d);
        end
    endtask

    task automatic rd_a(input int idx, input logic [63:0] exp, input string name);
        bus_a.csr_rd_en  = 1'b1;
        bus_a.csr_rd_idx = idx[1:0];
        step();
        bus_a.csr_rd_en  = 1'b0;
        check(name, bus_a.csr_rd_valid, bus_a.csr_rd_data, 1'b1, exp);
    endtask

    task automatic pulse_a(input logic [3:0] ev, input int n);
        for (int k = 0; k < n; k++) begin
            bus_a.events = ev;
            step();
        end
        bus_a.events = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus_a.events = '0; bus_a.csr_clr = 0; bus_a.csr_freeze = 0;
        bus_a.csr_rd_en = 0; bus_a.csr_rd_idx = '0;
        bus_b.events = '0; bus_b.csr_clr = 0; bus_b.csr_freeze = 0;
        bus_b.csr_rd_en = 0; bus_b.csr_rd_idx = '0;

        // Simultaneous pulses, freeze, then a mixed pattern; reads two cycles after last pulse.
        tbl[0]  = mk(4'b1111, 0, 0, 0, 0, 0, 64'd0);
        tbl[1]  = mk(4'b1111, 0, 0, 0, 0, 0, 64'd0);
        tbl[2]  = mk(4'b1111, 0, 0, 0, 0, 0, 64'd0);
        tbl[3]  = mk(4'b0000, 0, 0, 0, 0, 0, 64'd0);
        tbl[4]  = mk(4'b0000, 0, 0, 1, 0, 1, 64'd3);
        tbl[5]  = mk(4'b0000, 0, 0, 1, 1, 1, 64'd3);
        tbl[6]  = mk(4'b0000, 0, 0, 1, 2, 1, 64'd3);
        tbl[7]  = mk(4'b0000, 0, 0, 1, 3, 1, 64'd3);
        tbl[8]  = mk(4'b0000, 0, 0, 0, 0, 0, 64'd0);
        tbl[9]  = mk(4'b0000, 1, 0, 0, 0, 0, 64'd0);
        tbl[10] = mk(4'b0100, 0, 0, 0, 0, 0, 64'd0);
        tbl[11] = mk(4'b0100, 0, 0, 0, 0, 0, 64'd0);
        tbl[12] = mk(4'b0100, 0, 1, 0, 0, 0, 64'd0);
        tbl[13] = mk(4'b0100, 0, 1, 0, 0, 0, 64'd0);
        tbl[14] = mk(4'b0100, 0, 0, 0, 0, 0, 64'd0);
        tbl[15] = mk(4'b0000, 0, 0, 0, 0, 0, 64'd0);
        tbl[16] = mk(4'b0000, 0, 0, 1, 2, 1, 64'd3);
        tbl[17] = mk(4'b0000, 0, 0, 1, 1, 1, 64'd0);
        tbl[18] = mk(4'b0101, 0, 0, 0, 0, 0, 64'd0);
        tbl[19] = mk(4'b0011, 0, 0, 0, 0, 0, 64'd0);
        tbl[20] = mk(4'b0000, 0, 0, 0, 0, 0, 64'd0);
        tbl[21] = mk(4'b0000, 0, 0, 1, 0, 1, 64'd2);
        tbl[22] = mk(4'b0000, 0, 0, 1, 1, 1, 64'd1);
        tbl[23] = mk(4'b0000, 0, 0, 1, 2, 1, 64'd4);
        tbl[24] = mk(4'b0000, 0, 0, 1, 3, 1, 64'd0);

        step();
        step();
        check("reset_a", bus_a.csr_rd_valid, bus_a.csr_rd_data, 1'b0, 64'd0);
        check("reset_b", bus_b.csr_rd_valid, bus_b.csr_rd_data, 1'b0, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            bus_a.events     = tbl[i].ev;
            bus_a.csr_clr    = tbl[i].clr;
            bus_a.csr_freeze = tbl[i].frz;
            bus_a.csr_rd_en  = tbl[i].rd;
            bus_a.csr_rd_idx = tbl[i].idx;
            step();
            check($sformatf("vec%0d", i), bus_a.csr_rd_valid, bus_a.csr_rd_data,
                  tbl[i].exp_v, tbl[i].exp_d);
        end
        bus_a.events = '0; bus_a.csr_clr = 0; bus_a.csr_freeze = 0; bus_a.csr_rd_en = 0;

        // Read/clear collision (freeze also high: clear must still win).
        pulse_a(4'b0010, 6);
        step();
        step();
        bus_a.csr_clr = 1'b1; bus_a.csr_freeze = 1'b1;
        bus_a.csr_rd_en = 1'b1; bus_a.csr_rd_idx = 2'd1;
        step();
        check("collide_pre", bus_a.csr_rd_valid, bus_a.csr_rd_data, 1'b1, 64'd7);
        bus_a.csr_clr = 1'b0; bus_a.csr_freeze = 1'b0;
        step();
        check("collide_post", bus_a.csr_rd_valid, bus_a.csr_rd_data, 1'b1, 64'd0);
        bus_a.csr_rd_en = 1'b0;
        step();
        check("idle_after_rd", bus_a.csr_rd_valid, bus_a.csr_rd_data, 1'b0, 64'd0);

        // Overflow on an 8-bit counter, then confirm the flag is sticky.
        bus_a.csr_clr = 1'b1;
        step();
        bus_a.csr_clr = 1'b0;
        pulse_a(4'b0001, 255);
        step();
        step();
        rd_a(0, 64'h0000_0000_0000_00FF, "ovf_255");
        pulse_a(4'b0001, 1);
        step();
        step();
        rd_a(0, OVF_1, "ovf_256");
        pulse_a(4'b0001, 1);
        step();
        step();
        rd_a(0, OVF_2, "ovf_257");

        // Out-of-range read and back-to-back reads on the 3-channel instance.
        bus_b.events = 3'b111;
        step();
        bus_b.events = '0;
        step();
        step();
        bus_b.csr_rd_en = 1'b1; bus_b.csr_rd_idx = 2'd3;
        step();
        check("b_oor", bus_b.csr_rd_valid, bus_b.csr_rd_data, 1'b1, 64'd0);
        for (int i = 0; i < 3; i++) begin
            bus_b.csr_rd_idx = i[1:0];
            step();
            check($sformatf("b_b2b%0d", i), bus_b.csr_rd_valid, bus_b.csr_rd_data,
                  1'b1, 64'd1);
        end
        bus_b.csr_rd_en = 1'b0;
        step();
        check("b_idle", bus_b.csr_rd_valid, bus_b.csr_rd_data, 1'b0, 64'd0);

        // Reset mid-operation: events in flight and a read in the reset cycle.
        bus_a.events = 4'b1111;
        step();
        reset = 1'b1;
        bus_a.csr_rd_en = 1'b1; bus_a.csr_rd_idx = 2'd0;
        step();
        check("rst_no_valid", bus_a.csr_rd_valid, bus_a.csr_rd_data, 1'b0, 64'd0);
        reset = 1'b0;
        bus_a.events = '0; bus_a.csr_rd_en = 1'b0;
        step();
        check("rst_after", bus_a.csr_rd_valid, bus_a.csr_rd_data, 1'b0, 64'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            rd_a(i, 64'd0, $sformatf("rst_ctr%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
